mult_div_unit: RTL

//  Iterative 32-bit multiply/divide unit with architectural HI/LO registers for MULT/MULTU/DIV/DIVU.

---
 rtl/mult_div_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle; sign fix-up in a final cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             writeHi,
    input  logic             writeLo,
    input  logic [WIDTH-1:0] writeData,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [1:0]       dbg_state
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_bzero;
    logic               r_done;
    logic               r_dbz;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_up;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & operandA[WIDTH-1];
    assign w_b_neg  = w_signed & operandB[WIDTH-1];
    assign w_mag_a  = w_a_neg ? -operandA : operandA;
    assign w_mag_b  = w_b_neg ? -operandB : operandB;

    // Multiply: accumulator holds {partial product, remaining multiplier bits}.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

    // Divide: the 33-bit window is the partial remainder after the left shift.
    assign w_div_up   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff = w_div_up - {1'b0, r_opnd};
    assign w_div_ge   = ~w_div_diff[WIDTH];
    assign w_div_hi   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_up[WIDTH-1:0];
    assign w_div_lo   = {r_acc[WIDTH-2:0], w_div_ge};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_a_orig <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (writeHi) r_hi <= writeData;
                    if (writeLo) r_lo <= writeData;
                    if (start) begin
                        r_is_div <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_bzero  <= (operandB == '0);
                        r_a_orig <= operandA;
                        r_opnd   <= op[1] ? w_mag_b : w_mag_a;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
                        r_cnt    <= CW'(WIDTH - 1);
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? {w_div_hi, w_div_lo} : {w_mul_sum, r_acc[WIDTH-1:1]};
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    // A zero divisor returns the dividend as originally presented, not its magnitude.
                    if (r_is_div && r_bzero) begin
                        r_hi <= r_a_orig;
                        r_lo <= '1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done <= 1'b1;
                    r_dbz  <= r_is_div & r_bzero;
                end
                default: ;
            endcase
        end
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign divByZero = r_dbz;
    assign dbg_state = r_state;

endmodule
